// File: rtl/aes_stream_if.sv
// Streaming front end for a 128-bit AES core: assembles DATA_W beats into key/data blocks and serialises results.
// Key load pulse 2 cycles after the last key beat, start 1 cycle after the last data beat; one block in flight, output fully stallable.
module aes_stream_if #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_kind,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [127:0]      core_key,
  output logic              core_key_load,
  output logic [127:0]      core_blk,
  output logic              core_start_enc,
  output logic              core_start_dec,
  input  logic              core_done,
  input  logic [127:0]      core_res,
  output logic              busy
);

  localparam int BEATS = 128 / DATA_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  localparam logic [1:0] KIND_ENC  = 2'b00;
  localparam logic [1:0] KIND_DEC  = 2'b01;
  localparam logic [1:0] KIND_KEY  = 2'b10;
  localparam logic [1:0] KIND_DROP = 2'b11;

  typedef enum logic [2:0] {
    S_COLLECT,
    S_LDKEY,
    S_KEYPULSE,
    S_START,
    S_WAIT,
    S_SEND
  } state_e;

  state_e           state_q;
  logic [127:0]     blk_q;
  logic [127:0]     key_q;
  logic [1:0]       kind_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             out_valid_q;
  logic             key_load_q;
  logic             start_enc_q;
  logic             start_dec_q;

  logic [127:0]     blk_in_d;
  logic [127:0]     blk_out_d;
  logic [1:0]       kind_d;

  // Shifting by the full width yields zero, so DATA_W=128 needs no special case.
  assign blk_in_d  = (blk_q << DATA_W) | 128'(in_data);
  assign blk_out_d = blk_q << DATA_W;
  // On a single-beat block the tag has not been captured yet, so use the live input.
  assign kind_d    = (cnt_q == '0) ? in_kind : kind_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_COLLECT;
      blk_q       <= '0;
      key_q       <= '0;
      kind_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      key_load_q  <= 1'b0;
      start_enc_q <= 1'b0;
      start_dec_q <= 1'b0;
    end else begin
      key_load_q  <= 1'b0;
      start_enc_q <= 1'b0;
      start_dec_q <= 1'b0;
      case (state_q)
        S_COLLECT: begin
          if (in_valid) begin
            blk_q <= blk_in_d;
            if (cnt_q == '0) kind_q <= in_kind;
            if (cnt_q == LAST) begin
              cnt_q <= '0;
              case (kind_d)
                KIND_KEY: begin
                  state_q    <= S_LDKEY;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                end
                KIND_DROP: begin
                  busy_q <= 1'b0;
                end
                default: begin
                  state_q     <= S_START;
                  in_ready_q  <= 1'b0;
                  busy_q      <= 1'b1;
                  start_enc_q <= (kind_d == KIND_ENC);
                  start_dec_q <= (kind_d == KIND_DEC);
                end
              endcase
            end else begin
              cnt_q  <= cnt_q + 1'b1;
              busy_q <= 1'b1;
            end
          end
        end
        S_LDKEY: begin
          key_q      <= blk_q;
          key_load_q <= 1'b1;
          state_q    <= S_KEYPULSE;
        end
        S_KEYPULSE: begin
          state_q    <= S_COLLECT;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
        S_START: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            blk_q       <= core_res;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= S_SEND;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            blk_q <= blk_out_d;
            if (cnt_q == LAST) begin
              cnt_q       <= '0;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_COLLECT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q     <= S_COLLECT;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready       = in_ready_q;
  assign busy           = busy_q;
  assign out_valid      = out_valid_q;
  assign out_data       = blk_q[127 -: DATA_W];
  assign core_key       = key_q;
  assign core_key_load  = key_load_q;
  assign core_blk       = blk_q;
  assign core_start_enc = start_enc_q;
  assign core_start_dec = start_dec_q;

endmodule
